// File: rtl/df_pkg.sv
// Shared constants and state type for the D/F capture unit.
package df_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_DROP_W = 8;

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_HOLD    = 1'b1;

    typedef enum logic {
        S_COLLECT = ST_COLLECT,
        S_HOLD    = ST_HOLD
    } df_state_e;

endpackage

// File: rtl/df_shift_acc.sv
// One result-bit lane: shift register of the partial word plus a running ones count.
// Exposes the word/count including the current bit so the top can capture on the last sample.
module df_shift_acc
    import df_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             in_bit,
    output logic [WIDTH-1:0] word_next_c,
    output logic [CNT_W-1:0] ones_next_c
);

    // Only WIDTH-1 samples are ever held: the WIDTH-th one is captured and clears the lane.
    logic [WIDTH-2:0] sr;
    logic [CNT_W-1:0] acc;

    assign word_next_c = {sr, in_bit};
    assign ones_next_c = acc + CNT_W'(in_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            acc <= '0;
        end else if (clear) begin
            sr  <= '0;
            acc <= '0;
        end else if (shift_en) begin
            sr  <= word_next_c[WIDTH-2:0];
            acc <= ones_next_c;
        end
    end

endmodule

// File: rtl/df_capture_unit.sv
// Packs the D/F result streams into WIDTH-bit words with ones counts, presents them
// on a valid/ready port and counts samples lost while a word is held.
module df_capture_unit
    import df_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DROP_W = DEF_DROP_W,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_d,
    input  logic              in_f,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_d_word,
    output logic [WIDTH-1:0]  out_f_word,
    output logic [CNT_W-1:0]  out_d_ones,
    output logic [CNT_W-1:0]  out_f_ones,
    output logic [DROP_W-1:0] drop_count
);

    df_state_e        state;
    df_state_e        state_nxt;
    logic [CNT_W-1:0] sample_cnt;
    logic             accept_c;
    logic             last_c;
    logic             drop_c;
    logic             release_c;

    logic [WIDTH-1:0] d_word_c;
    logic [WIDTH-1:0] f_word_c;
    logic [CNT_W-1:0] d_ones_c;
    logic [CNT_W-1:0] f_ones_c;

    assign in_ready = (state == S_COLLECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes; out_ready only matters while a word is held.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        drop_c    = 1'b0;
        release_c = 1'b0;
        case (state)
            S_COLLECT: begin
                accept_c = in_valid;
                last_c   = in_valid && (sample_cnt == CNT_W'(WIDTH - 1));
                if (last_c) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                drop_c    = in_valid;
                release_c = out_ready;
                if (out_ready) begin
                    state_nxt = S_COLLECT;
                end
            end
        endcase
    end

    df_shift_acc #(.WIDTH(WIDTH)) u_d_lane (
        .clk         (clk),
        .rst         (rst),
        .clear       (last_c),
        .shift_en    (accept_c),
        .in_bit      (in_d),
        .word_next_c (d_word_c),
        .ones_next_c (d_ones_c)
    );

    df_shift_acc #(.WIDTH(WIDTH)) u_f_lane (
        .clk         (clk),
        .rst         (rst),
        .clear       (last_c),
        .shift_en    (accept_c),
        .in_bit      (in_f),
        .word_next_c (f_word_c),
        .ones_next_c (f_ones_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (last_c) begin
            sample_cnt <= '0;
        end else if (accept_c) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    // Output registers keep their last word after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_d_word <= '0;
            out_f_word <= '0;
            out_d_ones <= '0;
            out_f_ones <= '0;
        end else if (last_c) begin
            out_valid  <= 1'b1;
            out_d_word <= d_word_c;
            out_f_word <= f_word_c;
            out_d_ones <= d_ones_c;
            out_f_ones <= f_ones_c;
        end else if (release_c) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop_c && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_df_capture_unit.sv
// Bench for df_capture_unit: directed vector table, hand sequences and a random run
// against a queue-based word model.
module tb_df_capture_unit;

    localparam int unsigned W      = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned CW     = $clog2(W + 1);
    localparam int          DROP_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_d = 1'b0;
    logic          in_f = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_d_word;
    logic [W-1:0]  out_f_word;
    logic [CW-1:0] out_d_ones;
    logic [CW-1:0] out_f_ones;
    logic [DW-1:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    df_capture_unit #(.WIDTH(W), .DROP_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_d       (in_d),
        .in_f       (in_f),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_d_word (out_d_word),
        .out_f_word (out_f_word),
        .out_d_ones (out_d_ones),
        .out_f_ones (out_f_ones),
        .drop_count (drop_count)
    );

    // Reference model: samples queue up until a full word exists, then the word is held.
    bit         m_hold;
    bit         qd[$];
    bit         qf[$];
    logic [7:0] m_dw, m_fw;
    int         m_do, m_fo, m_drop;

    task automatic model_reset();
        m_hold = 0; qd.delete(); qf.delete();
        m_dw = 0; m_fw = 0; m_do = 0; m_fo = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit f, input bit r);
        if (!m_hold) begin
            if (v) begin
                qd.push_back(d);
                qf.push_back(f);
                if (qd.size() == W) begin
                    m_dw = 0; m_fw = 0; m_do = 0; m_fo = 0;
                    for (int i = 0; i < W; i++) begin
                        m_dw = {m_dw[6:0], qd[i]};
                        m_fw = {m_fw[6:0], qf[i]};
                        m_do += int'(qd[i]);
                        m_fo += int'(qf[i]);
                    end
                    qd.delete(); qf.delete();
                    m_hold = 1;
                end
            end
        end else begin
            if (v && m_drop < DROP_MAX) m_drop++;
            if (r) m_hold = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic cyc(input bit v, input bit d, input bit f, input bit r);
        @(negedge clk);
        in_valid = v; in_d = d; in_f = f; out_ready = r;
        model_step(v, d, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_hold));
        chk({tag, ".ready"}, 32'(in_ready), 32'(!m_hold));
        chk({tag, ".dword"}, 32'(out_d_word), 32'(m_dw));
        chk({tag, ".fword"}, 32'(out_f_word), 32'(m_fw));
        chk({tag, ".dones"}, 32'(out_d_ones), 32'(m_do));
        chk({tag, ".fones"}, 32'(out_f_ones), 32'(m_fo));
        chk({tag, ".drop"},  32'(drop_count), 32'(m_drop));
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".rst_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".rst_dword"}, 32'(out_d_word), 32'd0);
        chk({tag, ".rst_fword"}, 32'(out_f_word), 32'd0);
        chk({tag, ".rst_drop"},  32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         v, d, f, r;
        bit         e_valid;
        logic [7:0] e_dw, e_fw;
        int         e_do, e_fo, e_drop;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [7:0] dpat;
        logic [7:0] fpat;
        dpat = 8'hB1;
        fpat = 8'h55;

        tbl[0]  = '{1,1,0,0, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[1]  = '{1,0,1,0, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[2]  = '{1,1,0,0, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[3]  = '{1,1,1,0, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[4]  = '{1,0,0,0, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[5]  = '{1,0,1,0, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[6]  = '{1,0,0,0, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[7]  = '{1,1,1,0, 1, 8'hB1, 8'h55, 4, 4, 0};
        tbl[8]  = '{1,1,1,0, 1, 8'hB1, 8'h55, 4, 4, 1};
        tbl[9]  = '{1,0,0,0, 1, 8'hB1, 8'h55, 4, 4, 2};
        tbl[10] = '{1,1,0,0, 1, 8'hB1, 8'h55, 4, 4, 3};
        tbl[11] = '{0,0,0,0, 1, 8'hB1, 8'h55, 4, 4, 3};
        tbl[12] = '{1,1,1,1, 0, 8'hB1, 8'h55, 4, 4, 4};
        tbl[13] = '{0,0,0,0, 0, 8'hB1, 8'h55, 4, 4, 4};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por.valid", 32'(out_valid), 32'd0);
        chk("por.ready", 32'(in_ready), 32'd1);
        chk("por.drop",  32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back word, backpressure drops, release with a dropped sample.
        for (int i = 0; i < 14; i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            cyc(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
            chk({tg, ".valid"}, 32'(out_valid), 32'(tbl[i].e_valid));
            chk({tg, ".ready"}, 32'(in_ready), 32'(!tbl[i].e_valid));
            chk({tg, ".dword"}, 32'(out_d_word), 32'(tbl[i].e_dw));
            chk({tg, ".fword"}, 32'(out_f_word), 32'(tbl[i].e_fw));
            chk({tg, ".dones"}, 32'(out_d_ones), 32'(tbl[i].e_do));
            chk({tg, ".fones"}, 32'(out_f_ones), 32'(tbl[i].e_fo));
            chk({tg, ".drop"},  32'(drop_count), 32'(tbl[i].e_drop));
        end

        // Same word with idle gaps between samples.
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < (i % 3) + 1; g++) begin
                cyc(0, 1, 1, 1);
                chk("gap.idle_valid", 32'(out_valid), 32'd0);
            end
            cyc(1, dpat[7-i], fpat[7-i], 0);
            chk("gap.valid", 32'(out_valid), 32'(i == 7));
        end
        chk("gap.dword", 32'(out_d_word), 32'hB1);
        chk("gap.fword", 32'(out_f_word), 32'h55);
        chk("gap.dones", 32'(out_d_ones), 32'd4);
        chk("gap.fones", 32'(out_f_ones), 32'd4);
        chk("gap.drop",  32'(drop_count), 32'd4);
        cyc(0, 0, 0, 1);
        chk("gap.release_valid", 32'(out_valid), 32'd0);
        chk("gap.release_ready", 32'(in_ready), 32'd1);
        chk("gap.keep_dword", 32'(out_d_word), 32'hB1);

        // Reset while a word is held.
        for (int i = 0; i < 8; i++) cyc(1, dpat[7-i], fpat[7-i], 0);
        chk("hold.valid", 32'(out_valid), 32'd1);
        mid_reset("hold");

        // Partial word discarded by reset.
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
        mid_reset("partial");
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);
        chk("partial.valid", 32'(out_valid), 32'd1);
        chk("partial.dword", 32'(out_d_word), 32'hFF);
        chk("partial.dones", 32'(out_d_ones), 32'd8);
        chk("partial.fword", 32'(out_f_word), 32'h00);
        chk("partial.fones", 32'(out_f_ones), 32'd0);

        // Drop counter saturation while held.
        for (int i = 0; i < 300; i++) begin
            cyc(1, 0, 0, 0);
            if (i == 253) chk("sat.254", 32'(drop_count), 32'd254);
            if (i == 254) chk("sat.255", 32'(drop_count), 32'd255);
            if (i == 255) chk("sat.hold", 32'(drop_count), 32'd255);
        end
        chk("sat.end", 32'(drop_count), 32'd255);
        chk("sat.valid", 32'(out_valid), 32'd1);
        chk("sat.dword", 32'(out_d_word), 32'hFF);
        cyc(0, 0, 0, 1);
        chk("sat.release", 32'(in_ready), 32'd1);
        chk("sat.keep", 32'(drop_count), 32'd255);

        // Random traffic against the model.
        mid_reset("rnd");
        for (int i = 0; i < 3000; i++) begin
            bit v, d, f, r;
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) == 0);
            cyc(v, d, f, r);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
